// File: rtl/param_delay_unit.sv
// -----------------------------------------------------------------------------
// param_delay_unit
//
// Multi-lane elastic delay line. Each of N_CH lanes is a DEPTH-stage register
// pipeline with per-stage valid bits. Lanes keep full ready/valid backpressure
// and collapse bubbles. A word accepted into an empty, unstalled lane leaves
// exactly DEPTH cycles later. Lane outputs are routed either straight through
// or in reversed lane order.
//
// Parameters
//   N_CH    : number of independent lanes (>= 1)
//   WIDTH   : data bits per lane (>= 1)
//   DEPTH   : stages per lane, which is also the minimum latency (>= 1)
//   REVERSE : 1 routes input lane i to output lane N_CH-1-i, 0 routes i to i
//   OCW     : occupancy field width, $clog2(DEPTH+1)
//
// Ports
//   CLK          in   1          rising-edge clock
//   RESET        in   1          synchronous active-high reset
//   FLUSH        in   1          synchronous discard of all stored words
//   INPUT_data   in   N_CH*WIDTH lane i at [i*WIDTH +: WIDTH]
//   INPUT_valid  in   N_CH       per-lane producer valid
//   INPUT_ready  out  N_CH       per-lane accept
//   OUTPUT_data  out  N_CH*WIDTH per-output-lane data, same packing
//   OUTPUT_valid out  N_CH       per-output-lane valid
//   OUTPUT_ready in   N_CH       per-output-lane consumer ready
//   OCCUPANCY    out  N_CH*OCW   valid-stage count of input lane i
// -----------------------------------------------------------------------------
module param_delay_unit #(
  parameter int N_CH    = 2,
  parameter int WIDTH   = 5,
  parameter int DEPTH   = 3,
  parameter int REVERSE = 1,
  localparam int OCW    = $clog2(DEPTH + 1)
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    FLUSH,
  input  logic [N_CH*WIDTH-1:0]   INPUT_data,
  input  logic [N_CH-1:0]         INPUT_valid,
  output logic [N_CH-1:0]         INPUT_ready,
  output logic [N_CH*WIDTH-1:0]   OUTPUT_data,
  output logic [N_CH-1:0]         OUTPUT_valid,
  input  logic [N_CH-1:0]         OUTPUT_ready,
  output logic [N_CH*OCW-1:0]     OCCUPANCY
);

  // Number of set bits in a lane's valid vector.
  function automatic logic [OCW-1:0] popcount(input logic [DEPTH-1:0] vec);
    logic [OCW-1:0] cnt;
    cnt = {OCW{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      cnt = cnt + OCW'(vec[k]);
    end
    return cnt;
  endfunction

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    // Output lane fed by this input lane.
    localparam int OL = (REVERSE != 0) ? (N_CH - 1 - i) : i;

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [OCW-1:0]   occ_q;
    // load_s[s]: stage s can take a new word this cycle, i.e. it is empty or
    // its own word is moving on. load_s[s] for s>0 equals "stage s-1 advances".
    logic [DEPTH-1:0] load_s;
    logic             ready_s;
    logic             accept_s;

    // Ready chain from the consumer back to stage 0. Any empty stage at or
    // after s lets everything before it move, so the chain is a running OR
    // of empty-stage flags seeded with the consumer's ready.
    always_comb begin
      logic chain;
      chain  = OUTPUT_ready[OL];
      load_s = {DEPTH{1'b0}};
      for (int s = DEPTH - 1; s >= 0; s--) begin
        chain     = chain | ~v_q[s];
        load_s[s] = chain;
      end
    end

    assign ready_s        = ~RESET & ~FLUSH & load_s[0];
    assign accept_s       = INPUT_valid[i] & ready_s;
    assign INPUT_ready[i] = ready_s;

    // Next valid vector: a stage that can load takes its predecessor's valid
    // (or the accept flag at stage 0); a blocked stage is necessarily full
    // and keeps its word.
    always_comb begin
      v_d    = v_q;
      v_d[0] = load_s[0] ? accept_s : v_q[0];
      for (int s = 1; s < DEPTH; s++) begin
        v_d[s] = load_s[s] ? v_q[s-1] : v_q[s];
      end
    end

    // Valid bits and occupancy; reset and flush both empty the lane.
    always_ff @(posedge CLK) begin
      if (RESET || FLUSH) begin
        v_q   <= {DEPTH{1'b0}};
        occ_q <= {OCW{1'b0}};
      end else begin
        v_q   <= v_d;
        occ_q <= popcount(v_d);
      end
    end

    // Data stages load only when a real word moves in, so a stalled output
    // word stays stable.
    always_ff @(posedge CLK) begin
      if (RESET) begin
        for (int s = 0; s < DEPTH; s++) begin
          d_q[s] <= {WIDTH{1'b0}};
        end
      end else begin
        if (accept_s) begin
          d_q[0] <= INPUT_data[i*WIDTH +: WIDTH];
        end else begin
          d_q[0] <= d_q[0];
        end
        for (int s = 1; s < DEPTH; s++) begin
          if (load_s[s] && v_q[s-1]) begin
            d_q[s] <= d_q[s-1];
          end else begin
            d_q[s] <= d_q[s];
          end
        end
      end
    end

    assign OUTPUT_valid[OL]                = v_q[DEPTH-1];
    assign OUTPUT_data[OL*WIDTH +: WIDTH]  = d_q[DEPTH-1];
    assign OCCUPANCY[i*OCW +: OCW]         = occ_q;
  end

endmodule
